// File: rtl/machine_d_decoder.sv
// Receive-side decoder for the machine_d state/flag link: recovers the
// input bit of every checked transition and packs bits LSB-first into bytes.
module machine_d_decoder #(
    parameter int BYTE_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [2:0]        s_in,
    input  logic              f_in,
    input  logic              s_valid,
    input  logic              clr,
    output logic              x_bit,
    output logic              x_valid,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              err,
    output logic              overflow,
    output logic [1:0]        state_o
);
    localparam int CW = $clog2(BYTE_W);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SYNC  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [2:0]        p_q;
    logic [2:0]        s_exp;
    logic [BYTE_W-1:0] sr_q, sr_n;
    logic [CW-1:0]     cnt_q;
    logic              x_rec, f_exp, mismatch;
    logic              accept, sync_load, fault_hit, full;

    function automatic logic [2:0] step(input logic [2:0] p, input logic x);
        logic a, b, c;
        {a, b, c} = p;
        return {a | (b & ~x), (b & x) | (~b & ~x) | (a & ~x), c ^ x};
    endfunction

    always_comb begin
        x_rec     = p_q[0] ^ s_in[0];
        s_exp     = step(p_q, x_rec);
        f_exp     = (s_in == 3'b110);
        mismatch  = (s_in != s_exp) || (f_in != f_exp);
        state_n   = state_q;
        accept    = 1'b0;
        sync_load = 1'b0;
        fault_hit = 1'b0;
        unique case (state_q)
            RUN: begin
                if (s_valid) begin
                    if (mismatch) begin
                        fault_hit = 1'b1;
                        state_n   = FAULT;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            SYNC: begin
                if (s_valid) begin
                    sync_load = 1'b1;
                    state_n   = RUN;
                end
            end
            FAULT:   state_n = FAULT;
            default: state_n = SYNC;
        endcase
        // clr wins over any sample arriving in the same cycle
        if (clr) begin
            state_n   = SYNC;
            accept    = 1'b0;
            sync_load = 1'b0;
            fault_hit = 1'b0;
        end
        full        = accept && (cnt_q == CW'(BYTE_W - 1));
        sr_n        = sr_q;
        sr_n[cnt_q] = x_rec;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= RUN;
        else        state_q <= state_n;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            p_q        <= 3'b000;
            sr_q       <= '0;
            cnt_q      <= '0;
            x_bit      <= 1'b0;
            x_valid    <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            x_valid <= accept;
            if (accept) x_bit <= x_rec;
            if (accept || sync_load) p_q <= s_in;
            if (clr) begin
                err      <= 1'b0;
                overflow <= 1'b0;
                cnt_q    <= '0;
                sr_q     <= '0;
            end else begin
                if (fault_hit) err <= 1'b1;
                if (accept) begin
                    cnt_q <= cnt_q + 1'b1;
                    sr_q  <= full ? '0 : sr_n;
                end
                if (full && byte_valid && !byte_ready) overflow <= 1'b1;
            end
            if (full && (!byte_valid || byte_ready)) begin
                byte_out   <= sr_n;
                byte_valid <= 1'b1;
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end

    assign state_o = state_q;

endmodule
